// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: multi-digit 7-segment driver for a nibble display register.
// The register is loaded in parallel or shifted one digit at a time
// (keyboard-style entry). It is rendered as hex glyphs with optional
// leading-zero blanking and per-digit blinking. Segment outputs are registered,
// so a register change appears on o_hex_out one edge after it lands.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_clear,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_value_in,
  input  logic                    i_shift_en,
  input  logic [3:0]              i_digit_in,
  input  logic                    i_blank_lz,
  input  logic [NUM_DIGITS-1:0]   i_blink_en,
  output logic [7*NUM_DIGITS-1:0] o_hex_out,
  output logic [4*NUM_DIGITS-1:0] o_value_out,
  output logic                    o_ovf
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int HW = 7 * NUM_DIGITS;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [VW-1:0]         r_value;
  logic                  r_ovf;
  logic [CW-1:0]         r_blinkCnt;
  logic                  r_blinkPhase;
  logic [VW-1:0]         w_shifted;
  logic [3:0]            w_topNibble;
  logic [NUM_DIGITS-1:0] w_lzBlank;
  logic [NUM_DIGITS-1:0] w_blank;
  logic [HW-1:0]         w_hexNext;

  // Hex glyph for one nibble, already adjusted for the output polarity.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return ACTIVE_LOW ? ~s : s;
  endfunction

  // A single-digit display has nothing to keep on a shift, so the new digit
  // simply replaces the register.
  generate
    if (NUM_DIGITS == 1) begin : g_oneDigit
      assign w_shifted = i_digit_in;
    end else begin : g_multiDigit
      assign w_shifted = {r_value[VW-5:0], i_digit_in};
    end
  endgenerate

  assign w_topNibble = r_value[VW-1 -: 4];

  // Display register and sticky overflow: clear beats load beats shift.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
    end else if (i_load) begin
      r_value <= i_value_in;
      r_ovf   <= 1'b0;
    end else if (i_shift_en) begin
      r_value <= w_shifted;
      if (w_topNibble != 4'h0) r_ovf <= 1'b1;
    end
  end

  // Free-running blink timebase; the phase flips each time the counter wraps.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b1;
    end else if (r_blinkCnt == CNT_MAX) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= ~r_blinkPhase;
    end else begin
      r_blinkCnt <= r_blinkCnt + CW'(1);
    end
  end

  // Leading-zero mask: scan from the top digit down until a nonzero digit
  // appears. Digit 0 always stays visible so a zero value still reads "0".
  always_comb begin : p_leadingZero
    logic seenNonzero;
    seenNonzero = 1'b0;
    w_lzBlank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (r_value[4*i +: 4] != 4'h0) seenNonzero = 1'b1;
      w_lzBlank[i] = i_blank_lz && !seenNonzero && (i != 0);
    end
  end

  assign w_blank = w_lzBlank | (i_blink_en & {NUM_DIGITS{~r_blinkPhase}});

  // Next segment image: a blanked digit goes dark, otherwise it shows its glyph.
  always_comb begin
    w_hexNext = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_hexNext[7*i +: 7] = w_blank[i] ? SEG_OFF : encode(r_value[4*i +: 4]);
    end
  end

  // Registered segment outputs; reset darkens every digit immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) o_hex_out <= {NUM_DIGITS{SEG_OFF}};
    else         o_hex_out <= w_hexNext;
  end

  assign o_value_out = r_value;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl (6 digits, active-low, fast blink).
// The driver applies one stimulus per clock and pushes the expected outputs for
// the following edge into a scoreboard queue. The monitor pops one entry after
// every edge and compares it with the DUT outputs.
module tb_hex_display_ctrl;

  localparam int ND  = 6;
  localparam int DIV = 4;
  localparam logic [6:0] SEG_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [4*ND-1:0] value;
    logic            ovf;
    logic [7*ND-1:0] hex;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            clear = 1'b0;
  logic            load = 1'b0;
  logic [4*ND-1:0] valueIn = '0;
  logic            shiftEn = 1'b0;
  logic [3:0]      digitIn = '0;
  logic            blankLz = 1'b0;
  logic [ND-1:0]   blinkEn = '0;
  logic [7*ND-1:0] hexOut;
  logic [4*ND-1:0] valueOut;
  logic            ovf;

  exp_t            scoreQ[$];
  logic [4*ND-1:0] mValue;
  logic            mOvf;
  int              mEdges;
  int              vectors = 0;
  int              miscompares = 0;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .i_clk(clock), .i_reset(reset), .i_clear(clear), .i_load(load),
    .i_value_in(valueIn), .i_shift_en(shiftEn), .i_digit_in(digitIn),
    .i_blank_lz(blankLz), .i_blink_en(blinkEn),
    .o_hex_out(hexOut), .o_value_out(valueOut), .o_ovf(ovf)
  );

  always #5 clock = ~clock;

  // Expected segment image for a given register value and display settings.
  function automatic logic [7*ND-1:0] expectHex(input logic [4*ND-1:0] v, input logic blz,
                                                input logic [ND-1:0] ben, input logic phase);
    logic [7*ND-1:0] h;
    int msd;
    logic dark;
    msd = 0;
    for (int i = 0; i < ND; i++) if (v[4*i +: 4] != 4'h0) msd = i;
    for (int i = 0; i < ND; i++) begin
      dark = (blz && i > msd) || (ben[i] && !phase);
      h[7*i +: 7] = dark ? 7'h7F : ~SEG_TBL[v[4*i +: 4]];
    end
    return h;
  endfunction

  // Computes what the DUT shows after the coming edge, then advances the model.
  task automatic pushExpect();
    exp_t e;
    logic phase;
    phase = ((mEdges / DIV) % 2) == 0;
    e.hex = expectHex(mValue, blankLz, blinkEn, phase);
    if (clear) begin
      mValue = '0; mOvf = 1'b0;
    end else if (load) begin
      mValue = valueIn; mOvf = 1'b0;
    end else if (shiftEn) begin
      if (mValue[4*ND-1 -: 4] != 4'h0) mOvf = 1'b1;
      mValue = {mValue[4*ND-5:0], digitIn};
    end
    mEdges++;
    e.value = mValue;
    e.ovf   = mOvf;
    scoreQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic clr, input logic ld, input logic [4*ND-1:0] val,
                               input logic sh, input logic [3:0] dg, input logic blz,
                               input logic [ND-1:0] ben);
    @(negedge clock);
    clear = clr; load = ld; valueIn = val; shiftEn = sh; digitIn = dg;
    blankLz = blz; blinkEn = ben;
    pushExpect();
  endtask

  task automatic compareField(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("value_out", 64'(valueOut), 64'(e.value));
    compareField("ovf", 64'(ovf), 64'(e.ovf));
    compareField("hex_out", 64'(hexOut), 64'(e.hex));
  endtask

  // Pulses reset between edges, optionally in the middle of a pending
  // shift (mode 1) or load (mode 2), and checks the immediate reset state.
  task automatic doReset(input int mode);
    @(negedge clock);
    if (mode == 1) begin shiftEn = 1'b1; digitIn = 4'h9; end
    if (mode == 2) begin load = 1'b1; valueIn = 24'h456789; end
    #2 reset = 1'b1;
    #1;
    compareField("reset hex_out", 64'(hexOut), 64'({ND{7'h7F}}));
    compareField("reset value_out", 64'(valueOut), 64'd0);
    compareField("reset ovf", 64'(ovf), 64'd0);
    clear = 1'b0; load = 1'b0; shiftEn = 1'b0;
    #1 reset = 1'b0;
    mValue = '0; mOvf = 1'b0; mEdges = 0;
    scoreQ.delete();
    pushExpect();
  endtask

  // Monitor: one scoreboard entry is due shortly after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Driver: directed cases first, then randomized traffic with reset pulses.
  initial begin
    logic [4*ND-1:0] rv;
    doReset(0);
    applyStimulus(0, 1, 24'h12AB0F, 0, 4'h0, 0, '0);
    applyStimulus(0, 0, '0, 0, 4'h0, 0, '0);
    applyStimulus(1, 0, '0, 0, 4'h0, 1, '0);
    applyStimulus(0, 0, '0, 1, 4'h7, 1, '0);
    applyStimulus(0, 0, '0, 1, 4'h3, 1, '0);
    applyStimulus(0, 0, '0, 1, 4'h1, 1, '0);
    applyStimulus(0, 0, '0, 0, 4'h0, 1, '0);
    applyStimulus(0, 1, 24'h900000, 0, 4'h0, 0, '0);
    applyStimulus(0, 0, '0, 1, 4'h4, 0, '0);
    applyStimulus(0, 0, '0, 0, 4'h0, 0, '0);
    applyStimulus(0, 1, 24'h000005, 0, 4'h0, 0, '0);
    applyStimulus(1, 1, 24'h000005, 1, 4'h2, 0, '0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, '0, 0, 4'h0, 0, 6'b000001);
    for (int i = 0; i < 400; i++) begin
      if (i == 150) doReset(1);
      if (i == 300) doReset(2);
      for (int n = 0; n < ND; n++) rv[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, rv,
                    $urandom_range(0, 9) < 4, 4'($urandom), 1'($urandom),
                    ($urandom_range(0, 2) == 0) ? ND'($urandom) : '0);
    end
    for (int t = 0; t < 5 && scoreQ.size() != 0; t++) @(negedge clock);
    if (scoreQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", scoreQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
